// File: rtl/mips32_loader_pkg.sv
// Shared types and constants for the mips32 program loader.
// Opcodes are exported for encoding test programs.
package mips32_loader_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LEN_LO,
      DATA,
      CSUM,
      DONE,
      ERR
   } ld_state_t;

   localparam int BYTES_PER_WORD = 4;

   localparam logic [5:0] HLT  = 6'h3f;
   localparam logic [5:0] ADDI = 6'h0a;

endpackage

// File: rtl/mips32_word_packer.sv
// Assembles big-endian 32-bit words from a byte stream.
// o_word_valid pulses combinationally on the 4th byte.
module mips32_word_packer
   import mips32_loader_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  i_byte,
   input  logic        i_valid,
   input  logic        i_clear,
   output logic [31:0] o_word,
   output logic        o_word_valid
);

   localparam logic [1:0] LAST = 2'(BYTES_PER_WORD - 1);

   logic [1:0]  r_cnt;
   logic [23:0] r_asm;

   assign o_word       = {r_asm, i_byte};
   assign o_word_valid = i_valid && (r_cnt == LAST);

   // shift accepted bytes in, MSB first; clear drops partial word
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
         r_asm <= '0;
      end else if (i_clear) begin
         r_cnt <= '0;
         r_asm <= '0;
      end else if (i_valid) begin
         r_cnt <= r_cnt + 2'd1;
         r_asm <= {r_asm[15:0], i_byte};
      end
   end

endmodule

// File: rtl/mips32_prog_loader.sv
// Framed byte-stream loader for the mips32 instruction memory.
// Holds the core halted until a frame with a good checksum lands.
module mips32_prog_loader
   import mips32_loader_pkg::*;
#(
   parameter int          ADDR_W    = 10,
   parameter int unsigned BASE_ADDR = 0,
   parameter int unsigned MAX_WORDS = 1024
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic [7:0]        in_data,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              clear,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              core_hold,
   output logic              core_start,
   output logic              load_done,
   output logic              load_err,
   output logic [15:0]       word_cnt
);

   localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

   ld_state_t         r_state;
   ld_state_t         w_next;
   logic [7:0]        r_len_hi;
   logic [15:0]       r_len;
   logic [7:0]        r_csum;
   logic [15:0]       r_word_cnt;
   logic              r_we;
   logic [ADDR_W-1:0] r_addr;
   logic [31:0]       r_wdata;
   logic              r_start;

   logic              w_acc;
   logic              w_data_acc;
   logic [15:0]       w_len;
   logic [31:0]       w_word;
   logic              w_word_valid;
   logic              w_last_word;
   logic [ADDR_W-1:0] w_addr;

   assign in_ready   = (r_state == IDLE) || (r_state == LEN_LO)
                    || (r_state == DATA) || (r_state == CSUM);
   assign w_acc      = in_valid && in_ready && !clear;
   assign w_data_acc = w_acc && (r_state == DATA);
   assign w_len      = {r_len_hi, in_data};
   assign w_addr     = ADDR_W'(32'(BASE_ADDR) + 32'(r_word_cnt));
   assign w_last_word = w_word_valid
                     && ((r_word_cnt + 16'd1) == r_len);

   mips32_word_packer u_packer (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_byte       (in_data),
      .i_valid      (w_data_acc),
      .i_clear      (clear),
      .o_word       (w_word),
      .o_word_valid (w_word_valid)
   );

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next;
   end

   // next-state decode; clear overrides everything
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         IDLE:   if (w_acc) w_next = LEN_LO;
         LEN_LO: if (w_acc) begin
            if (32'(w_len) > MAX_WORDS) w_next = ERR;
            else if (w_len == 16'd0)    w_next = CSUM;
            else                        w_next = DATA;
         end
         DATA:   if (w_last_word) w_next = CSUM;
         CSUM:   if (w_acc) begin
            if (in_data == r_csum) w_next = DONE;
            else                   w_next = ERR;
         end
         DONE:   w_next = DONE;
         ERR:    w_next = ERR;
         default: w_next = IDLE;
      endcase
      if (clear) w_next = IDLE;
   end

   // length capture, checksum, word counter and write port
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_len_hi   <= '0;
         r_len      <= '0;
         r_csum     <= '0;
         r_word_cnt <= '0;
         r_we       <= 1'b0;
         r_addr     <= BASE;
         r_wdata    <= '0;
         r_start    <= 1'b0;
      end else begin
         r_we    <= w_word_valid;
         r_start <= (r_state != DONE) && (w_next == DONE);
         if (clear) begin
            r_csum     <= '0;
            r_word_cnt <= '0;
         end else begin
            if (w_acc && r_state == IDLE)   r_len_hi <= in_data;
            if (w_acc && r_state == LEN_LO) r_len    <= w_len;
            if (w_data_acc) r_csum <= r_csum ^ in_data;
            if (w_word_valid) begin
               r_wdata    <= w_word;
               r_addr     <= w_addr;
               r_word_cnt <= r_word_cnt + 16'd1;
            end
         end
      end
   end

   assign mem_we     = r_we;
   assign mem_addr   = r_addr;
   assign mem_wdata  = r_wdata;
   assign core_start = r_start;
   assign core_hold  = (r_state != DONE);
   assign load_done  = (r_state == DONE);
   assign load_err   = (r_state == ERR);
   assign word_cnt   = r_word_cnt;

endmodule

// File: tb/tb_mips32_prog_loader.sv
// Directed bench for mips32_prog_loader with a write scoreboard.
// Expected writes are queued when driven, compared when seen.
module tb_mips32_prog_loader;
   import mips32_loader_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  in_data = '0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic        clear = 1'b0;
   logic        mem_we;
   logic [9:0]  mem_addr;
   logic [31:0] mem_wdata;
   logic        core_hold;
   logic        core_start;
   logic        load_done;
   logic        load_err;
   logic [15:0] word_cnt;

   int n_checks = 0;
   int n_pass   = 0;
   int n_start  = 0;

   logic [41:0] q_exp[$];
   logic [41:0] q_obs[$];
   logic [31:0] prog[7];

   always #5 clk = ~clk;

   mips32_prog_loader dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .clear      (clear),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .core_hold  (core_hold),
      .core_start (core_start),
      .load_done  (load_done),
      .load_err   (load_err),
      .word_cnt   (word_cnt)
   );

   always @(negedge clk) begin
      if (mem_we) q_obs.push_back({mem_addr, mem_wdata});
      if (core_start) n_start++;
   end

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: got %h want %h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] b, input bit gaps);
      int t;
      t = 0;
      in_data  = b;
      in_valid = 1'b1;
      while (!in_ready && t < 20) begin
         tick();
         t++;
      end
      if (t >= 20) chk("ready_timeout", 32'd0, 32'd1);
      tick();
      in_valid = 1'b0;
      if (gaps) repeat ($urandom_range(0, 3)) tick();
   endtask

   task automatic send_word(input logic [31:0] w, input bit gaps);
      for (int k = 3; k >= 0; k--) send(w[8*k +: 8], gaps);
   endtask

   task automatic send_prog(input bit bad, input bit gaps);
      logic [7:0] cs;
      cs = 8'h00;
      send(8'h00, gaps);
      send(8'h07, gaps);
      for (int i = 0; i < 7; i++) begin
         q_exp.push_back({10'(i), prog[i]});
         cs = cs ^ prog[i][31:24] ^ prog[i][23:16]
                 ^ prog[i][15:8] ^ prog[i][7:0];
         send_word(prog[i], gaps);
      end
      send(bad ? ~cs : cs, gaps);
   endtask

   task automatic pulse_clear();
      clear = 1'b1;
      tick();
      clear = 1'b0;
   endtask

   task automatic drain(input string tag);
      logic [41:0] e;
      logic [41:0] o;
      repeat (4) tick();
      chk({tag, "_nwr"}, 32'(q_obs.size()), 32'(q_exp.size()));
      while (q_exp.size() > 0 && q_obs.size() > 0) begin
         e = q_exp.pop_front();
         o = q_obs.pop_front();
         chk({tag, "_addr"}, 32'(o[41:32]), 32'(e[41:32]));
         chk({tag, "_data"}, o[31:0], e[31:0]);
      end
      q_exp.delete();
      q_obs.delete();
   endtask

   initial begin
      int s0;
      prog[0] = 32'h2801000a;
      prog[1] = 32'h28020014;
      prog[2] = 32'h28030019;
      prog[3] = 32'h00222000;
      prog[4] = 32'h0ce77800;
      prog[5] = 32'h00832800;
      prog[6] = {HLT, 26'd0};
      chk("enc_addi", 32'(prog[0][31:26]), 32'(ADDI));

      #12;
      chk("rst_ready", 32'(in_ready), 32'd1);
      chk("rst_hold", 32'(core_hold), 32'd1);
      chk("rst_we", 32'(mem_we), 32'd0);
      chk("rst_done", 32'(load_done), 32'd0);
      chk("rst_wdata", mem_wdata, 32'd0);
      rst_n = 1'b1;
      tick();

      send_prog(1'b0, 1'b0);
      drain("s1");
      chk("s1_cnt", 32'(word_cnt), 32'd7);
      chk("s1_done", 32'(load_done), 32'd1);
      chk("s1_start", 32'(n_start), 32'd1);
      chk("s1_hold", 32'(core_hold), 32'd0);
      chk("s1_ready", 32'(in_ready), 32'd0);

      pulse_clear();
      chk("clr_done", 32'(load_done), 32'd0);
      chk("clr_hold", 32'(core_hold), 32'd1);
      chk("clr_cnt", 32'(word_cnt), 32'd0);
      send_prog(1'b1, 1'b0);
      drain("s2");
      chk("s2_err", 32'(load_err), 32'd1);
      chk("s2_start", 32'(n_start), 32'd1);
      chk("s2_hold", 32'(core_hold), 32'd1);
      chk("s2_ready", 32'(in_ready), 32'd0);

      pulse_clear();
      chk("clr_err", 32'(load_err), 32'd0);
      send(8'h04, 1'b0);
      send(8'h01, 1'b0);
      chk("s3_err", 32'(load_err), 32'd1);
      drain("s3");

      pulse_clear();
      send(8'h00, 1'b0);
      send(8'h00, 1'b0);
      chk("s4_csum_ready", 32'(in_ready), 32'd1);
      send(8'h00, 1'b0);
      drain("s4");
      chk("s4_done", 32'(load_done), 32'd1);
      chk("s4_cnt", 32'(word_cnt), 32'd0);
      chk("s4_start", 32'(n_start), 32'd2);

      pulse_clear();
      send_prog(1'b0, 1'b1);
      tick();
      in_data  = 8'h5a;
      in_valid = 1'b1;
      repeat (3) begin
         chk("s5_noacc", 32'(in_ready), 32'd0);
         tick();
      end
      in_valid = 1'b0;
      drain("s5");
      chk("s5_cnt", 32'(word_cnt), 32'd7);
      chk("s5_done", 32'(load_done), 32'd1);
      chk("s5_start", 32'(n_start), 32'd3);

      pulse_clear();
      send(8'h00, 1'b0);
      send(8'h03, 1'b0);
      q_exp.push_back({10'd0, prog[0]});
      q_exp.push_back({10'd1, prog[1]});
      send_word(prog[0], 1'b0);
      send_word(prog[1], 1'b0);
      send(8'h28, 1'b0);
      send(8'h03, 1'b0);
      in_data  = 8'haa;
      in_valid = 1'b1;
      clear    = 1'b1;
      tick();
      clear    = 1'b0;
      in_valid = 1'b0;
      chk("s6_idle", 32'(in_ready), 32'd1);
      chk("s6_cnt0", 32'(word_cnt), 32'd0);
      drain("s6a");
      q_exp.push_back({10'd0, 32'hfc000000});
      send(8'h00, 1'b0);
      send(8'h01, 1'b0);
      send(8'hfc, 1'b0);
      send(8'h00, 1'b0);
      send(8'h00, 1'b0);
      send(8'h00, 1'b0);
      chk("s6_we_lat", 32'(mem_we), 32'd1);
      chk("s6_wdata", mem_wdata, 32'hfc000000);
      chk("s6_cnt1", 32'(word_cnt), 32'd1);
      send(8'hfc, 1'b0);
      drain("s6b");
      chk("s6_done", 32'(load_done), 32'd1);

      pulse_clear();
      send(8'h00, 1'b0);
      send(8'h02, 1'b0);
      send_word(prog[0], 1'b0);
      send(8'h28, 1'b0);
      send(8'h02, 1'b0);
      s0 = n_start;
      #2;
      rst_n = 1'b0;
      #1;
      chk("ar_ready", 32'(in_ready), 32'd1);
      chk("ar_hold", 32'(core_hold), 32'd1);
      chk("ar_cnt", 32'(word_cnt), 32'd0);
      chk("ar_addr", 32'(mem_addr), 32'd0);
      chk("ar_wdata", mem_wdata, 32'd0);
      chk("ar_we", 32'(mem_we), 32'd0);
      q_obs.delete();
      q_exp.delete();
      repeat (2) tick();
      rst_n = 1'b1;
      send(8'h14, 1'b0);
      send(8'h00, 1'b0);
      drain("ar");
      chk("ar_start", 32'(n_start), 32'(s0));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
